mips_bus_arbiter: RTL and testbench

//   Shares the single Avalon-MM master port of mips_cpu_bus between two requesters:

---
 rtl/mips_bus_arbiter_pkg.sv | 26 ++
 rtl/mips_bus_arbiter.sv | 113 +++++++++++
 tb/tb_mips_bus_arbiter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/mips_bus_arbiter_pkg.sv
// rtl/mips_bus_arbiter_pkg.sv - shared types and grant rule for the mips_cpu_bus arbiter
package mips_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ACCESS,
        ARB_DONE
    } arb_state_t;

    typedef enum logic {
        ARB_PORT_FETCH = 1'b0,
        ARB_PORT_DATA  = 1'b1
    } arb_port_t;

    localparam logic [31:0] ARB_ABORT_DATA = 32'hDEADBEEF;

    // Ties go to data when fixed priority is set, otherwise to the port that did not win last time.
    function automatic arb_port_t arb_pick(input logic [1:0] req, input arb_port_t last,
                                           input logic fixed_prio);
        if (req == 2'b10) return ARB_PORT_DATA;
        if (req != 2'b11) return ARB_PORT_FETCH;
        if (fixed_prio) return ARB_PORT_DATA;
        return (last == ARB_PORT_FETCH) ? ARB_PORT_DATA : ARB_PORT_FETCH;
    endfunction

endpackage

// File: rtl/mips_bus_arbiter.sv
// rtl/mips_bus_arbiter.sv - two-port Avalon-MM master arbiter with registered bus and watchdog
module mips_bus_arbiter
    import mips_bus_arbiter_pkg::*;
#(
    parameter bit FIXED_PRIORITY = 1'b0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic [1:0]       req_i,
    input  logic [1:0]       we_i,
    input  logic [1:0][31:0] addr_i,
    input  logic [1:0][31:0] wdata_i,
    input  logic [1:0][3:0]  byteen_i,
    output logic [1:0]       done_o,
    output logic [31:0]      rdata_o,
    output logic             err_o,
    output logic             busy_o,
    output logic [31:0]      address,
    output logic             read,
    output logic             write,
    output logic [31:0]      writedata,
    output logic [3:0]       byteenable,
    input  logic             waitrequest,
    input  logic [31:0]      readdata
);

    localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [WD_W-1:0] WD_SAT  = '1;
    localparam bit WD_ENABLE = (TIMEOUT_CYCLES != 0);

    arb_state_t      state;
    arb_port_t       owner;
    arb_port_t       last_grant;
    arb_port_t       grant;
    logic [WD_W-1:0] wd;
    logic [1:0]      owner_onehot;

    always_comb begin
        grant        = arb_pick(req_i, last_grant, FIXED_PRIORITY);
        owner_onehot = (owner == ARB_PORT_DATA) ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk) begin
        if (!reset_i) begin
            state      <= ARB_IDLE;
            owner      <= ARB_PORT_FETCH;
            last_grant <= ARB_PORT_FETCH;
            wd         <= '0;
            address    <= '0;
            writedata  <= '0;
            byteenable <= '0;
            read       <= 1'b0;
            write      <= 1'b0;
            done_o     <= '0;
            rdata_o    <= '0;
            err_o      <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    done_o <= '0;
                    if (|req_i) begin
                        address    <= addr_i[grant];
                        writedata  <= wdata_i[grant];
                        byteenable <= byteen_i[grant];
                        read       <= ~we_i[grant];
                        write      <= we_i[grant];
                        owner      <= grant;
                        last_grant <= grant;
                        wd         <= '0;
                        busy_o     <= 1'b1;
                        state      <= ARB_ACCESS;
                    end
                end
                ARB_ACCESS: begin
                    if (!waitrequest) begin
                        if (read) rdata_o <= readdata;
                        read   <= 1'b0;
                        write  <= 1'b0;
                        done_o <= owner_onehot;
                        state  <= ARB_DONE;
                    end else begin
                        if (wd != WD_SAT) wd <= wd + WD_W'(1);
                        // A hung slave is abandoned; the requester still gets its done pulse.
                        if (WD_ENABLE && wd == WD_LAST) begin
                            read    <= 1'b0;
                            write   <= 1'b0;
                            err_o   <= 1'b1;
                            rdata_o <= ARB_ABORT_DATA;
                            done_o  <= owner_onehot;
                            state   <= ARB_DONE;
                        end
                    end
                end
                ARB_DONE: begin
                    done_o <= '0;
                    busy_o <= 1'b0;
                    state  <= ARB_IDLE;
                end
                default: begin
                    done_o <= '0;
                    busy_o <= 1'b0;
                    read   <= 1'b0;
                    write  <= 1'b0;
                    state  <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// tb/tb_mips_bus_arbiter.sv - randomized self-checking bench for mips_bus_arbiter
module tb_mips_bus_arbiter;

    localparam int TO = 8;

    logic             clk = 1'b0;
    logic             reset_i;
    logic [1:0]       req_i, we_i;
    logic [1:0][31:0] addr_i, wdata_i;
    logic [1:0][3:0]  byteen_i;
    logic             waitrequest;
    logic [31:0]      readdata;

    logic [1:0]  done0, done1;
    logic [31:0] rdata0, rdata1, address0, address1, writedata0, writedata1;
    logic        err0, err1, busy0, busy1, read0, read1, write0, write1;
    logic [3:0]  byteenable0, byteenable1;

    int n_tests = 0;
    int n_fail  = 0;

    int          m_last;
    logic [31:0] m_rdata;
    logic        m_err;

    logic        mon_en = 1'b0;
    logic        prev_hold = 1'b0;
    logic [67:0] prev_bus = '0;

    always #5 clk = ~clk;

    mips_bus_arbiter #(.FIXED_PRIORITY(1'b0), .TIMEOUT_CYCLES(TO)) dut0 (
        .clk(clk), .reset_i(reset_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .byteen_i(byteen_i), .done_o(done0), .rdata_o(rdata0),
        .err_o(err0), .busy_o(busy0), .address(address0), .read(read0), .write(write0),
        .writedata(writedata0), .byteenable(byteenable0), .waitrequest(waitrequest),
        .readdata(readdata)
    );

    mips_bus_arbiter #(.FIXED_PRIORITY(1'b1), .TIMEOUT_CYCLES(TO)) dut1 (
        .clk(clk), .reset_i(reset_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .byteen_i(byteen_i), .done_o(done1), .rdata_o(rdata1),
        .err_o(err1), .busy_o(busy1), .address(address1), .read(read1), .write(write1),
        .writedata(writedata1), .byteenable(byteenable1), .waitrequest(waitrequest),
        .readdata(readdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic raise(input int p);
        req_i[p]    = 1'b1;
        we_i[p]     = 1'($urandom);
        addr_i[p]   = $urandom;
        wdata_i[p]  = $urandom;
        byteen_i[p] = 4'($urandom_range(1, 15));
    endtask

    function automatic int pick(input logic [1:0] r, input int last);
        if (r == 2'b01) return 0;
        if (r == 2'b10) return 1;
        return 1 - last;
    endfunction

    // One arbitration round for dut0 starting in an IDLE cycle; w = slave wait cycles.
    task automatic do_round(input int w, input logic [31:0] rd, input int raise_pct);
        int          win, n;
        bit          abort;
        logic [31:0] a, d;
        logic [3:0]  be;
        logic        wr;
        if (req_i == 2'b00) begin
            step();
            check("idle_busy", busy0, 0);
            check("idle_rw", {read0, write0}, 0);
            check("idle_done", done0, 0);
            return;
        end
        win    = pick(req_i, m_last);
        m_last = win;
        a  = addr_i[win];
        wr = we_i[win];
        d  = wdata_i[win];
        be = byteen_i[win];
        abort = (w >= TO);
        n     = abort ? TO : w + 1;
        for (int j = 1; j <= n; j++) begin
            step();
            check("acc_read", read0, !wr);
            check("acc_write", write0, wr);
            check("acc_addr", address0, a);
            check("acc_wdata", writedata0, d);
            check("acc_be", byteenable0, be);
            check("acc_busy", busy0, 1);
            check("acc_done", done0, 0);
            waitrequest = (j <= w);
            readdata    = (j <= w) ? $urandom : rd;
            if (req_i[1-win] == 1'b0 && $urandom_range(0, 99) < raise_pct) raise(1 - win);
        end
        step();
        if (abort) begin
            m_rdata = 32'hDEADBEEF;
            m_err   = 1'b1;
        end else if (!wr) begin
            m_rdata = rd;
        end
        check("done_port", done0, (win == 1) ? 32'd2 : 32'd1);
        check("done_rdata", rdata0, m_rdata);
        check("done_err", err0, m_err);
        check("done_busy", busy0, 1);
        check("done_rw", {read0, write0}, 0);
        waitrequest = 1'b0;
        req_i[win]  = 1'b0;
        if ($urandom_range(0, 99) < raise_pct) raise(win);
        step();
        check("post_done", done0, 0);
        check("post_busy", busy0, 0);
        check("post_rw", {read0, write0}, 0);
        check("post_err", err0, m_err);
        check("post_rdata", rdata0, m_rdata);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("rw_excl0", read0 & write0, 0);
            check("rw_excl1", read1 & write1, 0);
            check("done_onehot0", $onehot0(done0), 1);
            check("done_onehot1", $onehot0(done1), 1);
            if (prev_hold) check("wait_stable", {address0, writedata0, byteenable0} == prev_bus, 1);
            prev_hold <= reset_i && (read0 | write0) && waitrequest;
            prev_bus  <= {address0, writedata0, byteenable0};
        end
    end

    initial begin
        int e0, w;
        reset_i = 1'b0; req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0; byteen_i = '0;
        waitrequest = 1'b0; readdata = '0;
        step();
        step();
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_rdata", rdata0, 0);
        check("rst_err", err0, 0);
        check("rst_rw", {read0, write0, read1, write1}, 0);
        check("rst_addr", address0, 0);
        check("rst_wdata", writedata0, 0);
        check("rst_be", byteenable0, 0);
        reset_i = 1'b1;
        m_last = 0; m_rdata = '0; m_err = 1'b0;
        mon_en = 1'b1;

        // Both ports requesting continuously.
        req_i = 2'b11; we_i = 2'b00;
        addr_i[0] = 32'h0000_0100; addr_i[1] = 32'h0000_0200;
        byteen_i[0] = 4'hF; byteen_i[1] = 4'hF;
        readdata = 32'hA5A5_0000;
        for (int r = 0; r < 4; r++) begin
            step();
            e0 = (r % 2 == 0) ? 1 : 0;
            check("tie_rr_addr", address0, addr_i[e0]);
            check("tie_fp_addr", address1, addr_i[1]);
            step();
            check("tie_rr_done", done0, (e0 == 1) ? 32'd2 : 32'd1);
            check("tie_fp_done", done1, 2'b10);
            step();
        end
        req_i = 2'b00;
        m_last = 0;
        m_rdata = 32'hA5A5_0000;

        // Zero-wait fetch read.
        we_i[0] = 1'b0; addr_i[0] = 32'hBFC0_0000; wdata_i[0] = '0; byteen_i[0] = 4'hF;
        req_i = 2'b01;
        do_round(0, 32'h1122_3344, 0);

        // Data write with three wait cycles.
        we_i[1] = 1'b1; addr_i[1] = 32'h1000_0040; wdata_i[1] = 32'hCAFE_F00D; byteen_i[1] = 4'b0011;
        req_i = 2'b10;
        do_round(3, 32'h0, 0);

        // Hung slave on a fetch read.
        we_i[0] = 1'b0; addr_i[0] = 32'h0000_0044; req_i = 2'b01;
        do_round(20, 32'h0, 0);

        for (int i = 0; i < 60; i++) begin
            for (int p = 0; p < 2; p++)
                if (!req_i[p] && $urandom_range(0, 1) == 1) raise(p);
            w = ($urandom_range(0, 9) == 0) ? 9 : $urandom_range(0, 4);
            do_round(w, $urandom, 30);
        end

        // Reset in the middle of a stalled access.
        req_i = 2'b00;
        step();
        we_i[1] = 1'b0; addr_i[1] = 32'h2000_0000; req_i = 2'b10; waitrequest = 1'b1;
        step();
        check("mid_read", read0, 1);
        step();
        step();
        reset_i = 1'b0;
        step();
        check("mrst_rw", {read0, write0}, 0);
        check("mrst_busy", busy0, 0);
        check("mrst_done", done0, 0);
        check("mrst_err", err0, 0);
        check("mrst_rdata", rdata0, 0);
        check("mrst_addr", address0, 0);
        reset_i = 1'b1; req_i = 2'b00; waitrequest = 1'b0;
        step();
        check("mrst_done2", done0, 0);
        check("mrst_busy2", busy0, 0);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
